bram_readback_checker: RTL and testbench

Read-side counterpart to the overclocked write path on the test platform. After the design under test has filled the result BRAM, a rising edge on `read_enable` makes this block sweep every result address, compare each word against a golden ROM, and count mismatches. The outcome is shown on the board LEDs and on status ports for ChipScope capture. It sits in `platform_top` between the result BRAM read port, the golden ROM, and `led`.

---
 rtl/bram_readback_checker.sv | 99 +++++++++
 tb/tb_bram_readback_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bram_readback_checker.sv
// bram_readback_checker: sweeps the result BRAM against the golden ROM and counts mismatches; CHECKER_FIRST_ERR_EN adds first-mismatch capture
module bram_readback_checker #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              read_enable,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] gold_dout,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [7:0]        led
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic re_q;
  logic [2:0] cnt;
  logic [RD_LAT-1:0] vpipe;
  logic start, mis;
  assign start = state == IDLE && read_enable && !re_q;
  assign mis = vpipe[RD_LAT-1] && ram_dout != gold_dout;
  assign busy = state == READ || state == DRAIN;
  assign led = {done, done && err_count == '0,
                err_count > (ADDR_W+1)'(63) ? 6'h3f : err_count[5:0]};
  // re_q resets high so a level held through reset cannot look like an edge
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state     <= IDLE;
      re_q      <= 1'b1;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
      err_count <= '0;
      cnt       <= '0;
      vpipe     <= '0;
    end else begin
      re_q  <= read_enable;
      vpipe <= RD_LAT'({vpipe, mem_en});
      if (mis && !(&err_count)) err_count <= err_count + 1'b1;
      case (state)
        IDLE: if (start) begin
          state     <= READ;
          mem_en    <= 1'b1;
          mem_addr  <= '0;
          err_count <= '0;
        end
        READ: if (mem_addr == ADDR_W'(DEPTH-1)) begin
          state  <= DRAIN;
          mem_en <= 1'b0;
          cnt    <= '0;
        end else mem_addr <= mem_addr + 1'b1;
        DRAIN: if (cnt == 3'(RD_LAT-1)) begin
          state <= DONE;
          done  <= 1'b1;
        end else cnt <= cnt + 1'b1;
        DONE: if (!read_enable) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CHECKER_FIRST_ERR_EN
  logic [ADDR_W-1:0] apipe [RD_LAT];
  logic found;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      found          <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
      for (int i = 0; i < RD_LAT; i++) apipe[i] <= '0;
    end else begin
      apipe[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
      if (start) begin
        found          <= 1'b0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (mis && !found) begin
        found          <= 1'b1;
        first_err_addr <= apipe[RD_LAT-1];
        first_err_data <= ram_dout;
      end
    end
  end
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif
endmodule

// File: tb/tb_bram_readback_checker.sv
// tb_bram_readback_checker: random and directed sweeps checked against a mismatch-counting memory model
module tb_bram_readback_checker;
  localparam int ADDR_W = 10, DATA_W = 8, DEPTH = 1024, RD_LAT = 2;
  localparam int LEN = DEPTH + RD_LAT;
  localparam int ERR_MAX = (1 << (ADDR_W + 1)) - 1;
  logic sys_clk = 1'b0, sys_rst, read_enable, mem_en, busy, done;
  logic [ADDR_W-1:0] mem_addr, first_err_addr;
  logic [DATA_W-1:0] ram_dout, gold_dout, first_err_data;
  logic [ADDR_W:0] err_count;
  logic [7:0] led;
  logic [DATA_W-1:0] ram [DEPTH], gold [DEPTH];
  logic [DATA_W-1:0] rp [RD_LAT], gp [RD_LAT];
  int n_chk = 0, n_fail = 0;

  bram_readback_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .read_enable(read_enable), .mem_en(mem_en),
    .mem_addr(mem_addr), .ram_dout(ram_dout), .gold_dout(gold_dout), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data), .led(led));

  always #5 sys_clk = ~sys_clk;

  // memories with RD_LAT cycles of read latency
  always @(posedge sys_clk) begin
    if (mem_en) begin
      rp[0] <= ram[mem_addr];
      gp[0] <= gold[mem_addr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rp[i] <= rp[i-1];
      gp[i] <= gp[i-1];
    end
  end
  assign ram_dout = rp[RD_LAT-1];
  assign gold_dout = gp[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_addr", first_err_addr, 0);
    chk("rst_first_data", first_err_data, 0);
    chk("rst_led", led, 0);
  endtask

  // One run: model result from array contents, then per-cycle checks of the sweep
  task automatic run(input int abort_at, input bit toggle,
                     output logic [31:0] ge, output logic [31:0] gl,
                     output logic [31:0] ga, output logic [31:0] gd);
    int e = 0, fa = 0, fd = 0, sat;
    bit hit = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] != gold[i]) begin
        if (!hit) begin fa = i; fd = ram[i]; hit = 1; end
        e++;
      end
    if (e > ERR_MAX) e = ERR_MAX;
    sat = e > 63 ? 63 : e;
`ifndef CHECKER_FIRST_ERR_EN
    fa = 0; fd = 0;
`endif
    ge = 0; gl = 0; ga = 0; gd = 0;
    read_enable = 1'b1;
    @(negedge sys_clk);
    for (int j = 0; j <= LEN; j++) begin
      if (j == abort_at) begin
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_reset();
        sys_rst = 1'b1;
        return;
      end
      chk("busy", busy, j < LEN);
      chk("done", done, j == LEN);
      chk("mem_en", mem_en, j < DEPTH);
      if (j < DEPTH) chk("mem_addr", mem_addr, j);
      if (j < LEN) begin
        if (toggle) read_enable = 1'($urandom_range(0, 1));
        @(negedge sys_clk);
      end
    end
    ge = err_count; gl = led; ga = first_err_addr; gd = first_err_data;
    chk("err_count", err_count, e);
    chk("led", led, {24'd0, 1'b1, e == 0, 6'(sat)});
    chk("first_err_addr", first_err_addr, fa);
    chk("first_err_data", first_err_data, fd);
    read_enable = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      chk("done_hold", done, 1);
      chk("no_restart", busy, 0);
    end
    read_enable = 1'b0;
    @(negedge sys_clk);
    chk("idle_done", done, 0);
    chk("idle_err_held", err_count, e);
    chk("idle_led", led, {24'd0, 2'b00, 6'(sat)});
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      gold[i] = 8'($urandom);
      ram[i] = mode == 1 ? ~gold[i] :
               mode == 2 && $urandom_range(0, 7) == 0 ? gold[i] ^ 8'($urandom_range(1, 255)) : gold[i];
    end
  endtask

  logic [31:0] ge, gl, ga, gd;
  initial begin
    sys_rst = 1'b0;
    read_enable = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk_reset();
    sys_rst = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      chk("held_high_no_start", busy, 0);
    end
    read_enable = 1'b0;
    @(negedge sys_clk);

    fill(0);
    run(-1, 0, ge, gl, ga, gd);
    chk("t1_err", ge, 0);
    chk("t1_led", gl, 32'hC0);

    ram[5] = 8'hA5; gold[5] = 8'h5A;
    run(-1, 0, ge, gl, ga, gd);
    chk("t2_err", ge, 1);
    chk("t2_led", gl, 32'h81);
`ifdef CHECKER_FIRST_ERR_EN
    chk("t2_first_addr", ga, 5);
    chk("t2_first_data", gd, 32'hA5);
`else
    chk("t2_first_addr", ga, 0);
    chk("t2_first_data", gd, 0);
`endif

    fill(1);
    run(-1, 0, ge, gl, ga, gd);
    chk("t3_err", ge, 1024);
    chk("t3_led", gl, 32'hBF);

    fill(0);
    ram[5] = 8'hA5; gold[5] = 8'h5A;
    run(300, 0, ge, gl, ga, gd);
    repeat (3) begin
      @(negedge sys_clk);
      chk("abort_no_start", busy, 0);
    end
    read_enable = 1'b0;
    @(negedge sys_clk);
    run(-1, 0, ge, gl, ga, gd);
    chk("t4_err", ge, 1);

    fill(2);
    run(-1, 1, ge, gl, ga, gd);
    run(-1, 0, ge, gl, ga, gd);

    repeat (3) begin
      fill(2);
      run(-1, 0, ge, gl, ga, gd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
